board_io_ctrl: RTL

Parametrised board I/O conditioner between raw push-buttons and a JTAG reset source on one side, and the MPSoC's reset and external-interrupt inputs on the other. It provides:
- synchronisation and debouncing of an arbitrary number of keys;
- a combined, stretched SoC reset built from the system reset, a dedicated reset key and the JTAG reset;
- latched external interrupts with selectable trigger mode and per-channel acknowledge.

It replaces direct inversion of key pins into reset and interrupt lines.

---
 rtl/board_io_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/board_io_ctrl.sv
// -----------------------------------------------------------------------------
// board_io_ctrl
//
// Conditions raw board inputs for the MPSoC:
//   - two-flop synchronisation and per-key debouncing of KEY_NUM push-buttons
//   - a stretched SoC reset combining the system reset, the JTAG reset request
//     and the debounced reset key (key 0)
//   - latched external interrupts for keys 1..KEY_NUM-1 with a selectable
//     trigger mode and per-channel acknowledge
//
// Ports
//   clk           in   1          system clock
//   reset         in   1          synchronous, active-high reset
//   key_i         in   KEY_NUM    raw asynchronous key pins
//   jtag_reset_i  in   1          JTAG reset request (clk domain, active-high)
//   int_ack_i     in   KEY_NUM-1  per-channel acknowledge pulse
//   soc_reset_o   out  1          stretched SoC reset, active-high
//   key_state_o   out  KEY_NUM    debounced pressed state (1 = pressed)
//   ext_int_o     out  KEY_NUM-1  interrupt request, bit n belongs to key n+1
//
// INT_MODE is one of "LEVEL", "RISE", "FALL", "BOTH" and is evaluated on the
// debounced pressed state.
// -----------------------------------------------------------------------------
module board_io_ctrl #(
   parameter int    KEY_NUM            = 4,
   parameter bit    KEY_ACTIVE_LOW     = 1'b1,
   parameter int    DEBOUNCE_CYCLES    = 500000,
   parameter int    CNT_WIDTH          = 20,
   parameter int    RST_STRETCH_CYCLES = 16,
   parameter string INT_MODE           = "RISE"
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [KEY_NUM-1:0] key_i,
   input  logic               jtag_reset_i,
   input  logic [KEY_NUM-2:0] int_ack_i,
   output logic               soc_reset_o,
   output logic [KEY_NUM-1:0] key_state_o,
   output logic [KEY_NUM-2:0] ext_int_o
);

   localparam int NCH = KEY_NUM - 1;
   localparam int SW  = $clog2(RST_STRETCH_CYCLES + 1);

   localparam logic [KEY_NUM-1:0]   RELEASED_LVL = KEY_ACTIVE_LOW ? '1 : '0;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST     = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0]        STRETCH_LOAD = SW'(RST_STRETCH_CYCLES);
   localparam logic [SW-1:0]        STRETCH_ONE  = SW'(1);

   localparam bit MODE_LEVEL = (INT_MODE == "LEVEL");
   localparam bit MODE_RISE  = (INT_MODE == "RISE");
   localparam bit MODE_FALL  = (INT_MODE == "FALL");
   localparam bit MODE_BOTH  = (INT_MODE == "BOTH");

   // ------------------------------------------------------------------
   // Synchroniser
   // ------------------------------------------------------------------
   // Both stages come out of reset at the released pin level so that no
   // phantom press is seen while the chain fills.
   logic [KEY_NUM-1:0] sync1_q;
   logic [KEY_NUM-1:0] sync2_q;
   logic [KEY_NUM-1:0] pressed_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= RELEASED_LVL;
         sync2_q <= RELEASED_LVL;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

   assign pressed_sync = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

   // ------------------------------------------------------------------
   // Debounce
   // ------------------------------------------------------------------
   // The counter only runs while the synchronised value disagrees with the
   // accepted state; any agreement (a glitch ending) drops it back to zero,
   // and reaching the last count flips the state instead of wrapping.
   logic [CNT_WIDTH-1:0] cnt_q [KEY_NUM];
   logic [CNT_WIDTH-1:0] cnt_d [KEY_NUM];
   logic [KEY_NUM-1:0]   stable_q;
   logic [KEY_NUM-1:0]   stable_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '{default: '0};
      for (int k = 0; k < KEY_NUM; k++) begin
         if (pressed_sync[k] != stable_q[k]) begin
            if (cnt_q[k] == CNT_LAST) begin
               stable_d[k] = ~stable_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '{default: '0};
         stable_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign key_state_o = stable_q;

   // ------------------------------------------------------------------
   // Reset generator
   // ------------------------------------------------------------------
   // The stretch counter holds the number of inactive edges still needed.
   // soc_reset drops on the edge that takes the counter from 1 to 0, which
   // is the RST_STRETCH_CYCLES-th consecutive inactive edge.
   logic          src_active;
   logic [SW-1:0] stretch_q;
   logic [SW-1:0] stretch_d;
   logic          soc_q;
   logic          soc_d;

   assign src_active = reset | jtag_reset_i | stable_q[0];

   always_comb begin
      stretch_d = stretch_q;
      soc_d     = soc_q;
      if (src_active) begin
         stretch_d = STRETCH_LOAD;
         soc_d     = 1'b1;
      end else if (stretch_q != '0) begin
         stretch_d = stretch_q - 1'b1;
         soc_d     = (stretch_q != STRETCH_ONE);
      end else begin
         soc_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stretch_q <= STRETCH_LOAD;
         soc_q     <= 1'b1;
      end else begin
         stretch_q <= stretch_d;
         soc_q     <= soc_d;
      end
   end

   assign soc_reset_o = soc_q;

   // ------------------------------------------------------------------
   // Interrupts
   // ------------------------------------------------------------------
   // Events are taken from the debounce next-state so a pending bit is set
   // on the very edge key_state_o toggles. The clear condition covers both
   // the current and the next reset level so nothing leaks in on either the
   // assert or the release edge of soc_reset.
   logic [NCH-1:0] rise_evt;
   logic [NCH-1:0] fall_evt;
   logic [NCH-1:0] evt;
   logic           int_clear;
   logic [NCH-1:0] int_q;
   logic [NCH-1:0] int_d;

   assign rise_evt  = stable_d[KEY_NUM-1:1] & ~stable_q[KEY_NUM-1:1];
   assign fall_evt  = ~stable_d[KEY_NUM-1:1] & stable_q[KEY_NUM-1:1];
   assign int_clear = soc_q | soc_d;

   always_comb begin
      evt = '0;
      if (MODE_RISE) begin
         evt = rise_evt;
      end else if (MODE_FALL) begin
         evt = fall_evt;
      end else if (MODE_BOTH) begin
         evt = rise_evt | fall_evt;
      end
   end

   always_comb begin
      int_d = int_q;
      if (int_clear) begin
         int_d = '0;
      end else if (MODE_LEVEL) begin
         int_d = stable_d[KEY_NUM-1:1];
      end else begin
         // A new event overrides a simultaneous acknowledge.
         int_d = (int_q & ~int_ack_i) | evt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         int_q <= '0;
      end else begin
         int_q <= int_d;
      end
   end

   assign ext_int_o = int_q;

endmodule
